uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte buffer and transmit sequencer directly upstream of uart_tx.
- Accepts bytes from the system side into a circular FIFO and hands them to uart_tx one at a time, using a single-cycle write pulse.
- Tracks uart_tx busy/done/error to pace transfers, detects a stalled transmitter, and keeps sticky status for software.

Parameters:
- DATA_W, `NUM_DATA_BITS (8): byte width. Must equal uart_tx data width.
- DEPTH, 16: FIFO entries. Power of two, at least 2. ADDR_W = $clog2(DEPTH).
- BUSY_TIMEOUT, 4: clk cycles allowed between the write pulse and tx_busy rising. Must be at least 1.

Ports:
- clk  in  1  single clock; the same net that drives uart_tx baud.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  transmit path enable; passed through to uart_tx.
- wr_en  in  1  push strobe from the system side.
- wr_data  in  DATA_W  byte to push.
- flush  in  1  discard all queued bytes.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  ADDR_W+1  number of queued bytes.
- tx_enable  out  1  drives uart_tx enable.
- tx_write  out  1  drives uart_tx write.
- tx_data  out  DATA_W  drives uart_tx data.
- tx_busy  in  1  from uart_tx busy.
- tx_done  in  1  from uart_tx done.
- tx_error  in  1  from uart_tx error.
- overflow  out  1  sticky: a push was attempted while full.
- timeout  out  1  sticky: tx_busy did not rise within BUSY_TIMEOUT.
- err_cnt  out  8  saturating count of failed transfers.
- clr_status  in  1  clears overflow, timeout and err_cnt.

Behaviour:
- Reset, asynchronous: rd_ptr=0, wr_ptr=0, state=IDLE, tx_write=0, tx_data=0, overflow=0, timeout=0, err_cnt=0. Consequently empty=1, full=0, level=0.
- Pointers are ADDR_W+1 bits and wrap naturally.
  - level = wr_ptr - rd_ptr.
  - empty when the pointers are equal.
  - full when the MSBs differ and the low bits are equal.
- tx_enable = enable, combinational.
- Push: when wr_en && !full, write mem[wr_ptr] and increment wr_ptr.
  - wr_en && full drops the byte and sets overflow.
  - full is evaluated before any same-cycle pop, so a push at full is rejected even if a pop occurs that cycle.
- Pop happens only on the IDLE->START transition.
- State machine (registered):
  - IDLE: if enable && !empty && !flush, then tx_data <= mem[rd_ptr], rd_ptr++, go to START.
  - START: tx_write=1 for exactly this cycle; clear timer; go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy, go to WAIT_DONE. Otherwise timer++. When timer == BUSY_TIMEOUT, set timeout, err_cnt++, go to IDLE; the byte is lost.
  - WAIT_DONE: when tx_done, do err_cnt++ if tx_error is high in that cycle, then go to IDLE.
  - tx_write is 0 in every state except START.
- Throughput: the minimum time from tx_done to the next tx_write pulse is 2 cycles (IDLE, START).
- enable low in any state: the next state is IDLE and the in-flight byte is abandoned. FIFO contents are retained and tx_data holds its value.
- flush:
  - rd_ptr <= wr_ptr, and any push in the same cycle is ignored.
  - An in-flight transfer completes normally.
  - In IDLE, flush blocks the pop in that cycle.
- clr_status has priority over a same-cycle set or increment of overflow, timeout or err_cnt.
- err_cnt saturates at 255.
- No combinational path from wr_en to tx_write.

Decomposition:
- uart_globals.svh holds:
  - `NUM_DATA_BITS`;
  - new feeder state encodings `FEED_IDLE`, `FEED_START`, `FEED_WAIT_BUSY`, `FEED_WAIT_DONE`;
  - the default DEPTH and BUSY_TIMEOUT values.
- One sub-module, uart_sync_fifo: memory, pointers, full/empty/level, flush. This keeps the sequencer FSM separate and lets the planned uart_rx drain buffer reuse it.

Test Plan:
- Reset, then push 0xA5, 0x3C with enable=1 and a uart_tx model that raises busy 1 cycle after write and done 10 cycles later:
  - two tx_write pulses, with tx_data 0xA5 then 0x3C;
  - a gap of 2 cycles from the first done to the second write;
  - empty=1 at the end.
- enable=0, push 17 bytes with DEPTH=16:
  - full=1 and level=16 after 16 pushes;
  - the 17th push sets overflow, and level stays 16;
  - after enable=1 the bytes drain in order 0..15.
- Model never asserts tx_busy:
  - timeout=1 four cycles after the write pulse and err_cnt=1;
  - the next queued byte is then issued.
- Model asserts tx_error with done:
  - err_cnt increments to 1;
  - clr_status coincident with a second error leaves err_cnt=0.
- Deassert enable in WAIT_DONE with 3 bytes queued:
  - FSM goes to IDLE with no write pulse;
  - level stays 2;
  - re-enable sends the remaining 2 bytes.
- Assert reset mid-WAIT_DONE with 5 bytes queued:
  - all outputs return to reset values immediately, without waiting for a clk edge;
  - level=0.

Source files
------------

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the uart_tx feeder: global widths, state codes and defaults.
// The macro block stands in for the common uart globals so the package is self-contained.
`ifndef UART_GLOBALS_SVH
`define UART_GLOBALS_SVH
`define NUM_DATA_BITS 8
`define FEED_IDLE 2'd0
`define FEED_START 2'd1
`define FEED_WAIT_BUSY 2'd2
`define FEED_WAIT_DONE 2'd3
`define FEED_DEPTH_DEFAULT 16
`define FEED_BUSY_TIMEOUT_DEFAULT 4
`endif

package uart_tx_feeder_pkg;

    localparam int FEED_DATA_W = `NUM_DATA_BITS;
    localparam int FEED_DEPTH = `FEED_DEPTH_DEFAULT;
    localparam int FEED_BUSY_TIMEOUT = `FEED_BUSY_TIMEOUT_DEFAULT;

    typedef enum logic [1:0] {
        S_IDLE      = `FEED_IDLE,
        S_START     = `FEED_START,
        S_WAIT_BUSY = `FEED_WAIT_BUSY,
        S_WAIT_DONE = `FEED_WAIT_DONE
    } feed_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with wrap-bit pointers and a flush that drops all queued data.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;

    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Fullness is judged on the registered pointers, before any same-cycle pop.
    assign push_ok = push_i && !full_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system bytes and paces them into uart_tx one write pulse at a time,
// watching busy/done/error and keeping sticky status for software.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_W = `NUM_DATA_BITS,
    parameter int DEPTH = `FEED_DEPTH_DEFAULT,
    parameter int BUSY_TIMEOUT = `FEED_BUSY_TIMEOUT_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              tx_enable,
    output logic              tx_write,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              tx_error,
    output logic              overflow,
    output logic              timeout,
    output logic [7:0]        err_cnt,
    input  logic              clr_status
);

    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    feed_state_e       state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              pop;
    logic              err_inc;
    logic              to_set;
    logic [DATA_W-1:0] fifo_rdata;

    uart_sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (wr_en),
        .pop_i  (pop),
        .flush_i(flush),
        .wdata_i(wr_data),
        .rdata_o(fifo_rdata),
        .full_o (full),
        .empty_o(empty),
        .level_o(level)
    );

    assign tx_enable = enable;
    assign tx_write  = (state_q == S_START);
    assign tx_data   = tx_data_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        err_inc   = 1'b0;
        to_set    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!empty && !flush) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rdata;
                    state_d   = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    err_inc = tx_error;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling abandons the in-flight byte but keeps the queue and tx_data.
        if (!enable) begin
            state_d   = S_IDLE;
            pop       = 1'b0;
            tx_data_d = tx_data_q;
            err_inc   = 1'b0;
            to_set    = 1'b0;
        end

        overflow_d = overflow_q | (wr_en & full);
        timeout_d  = timeout_q | to_set;
        err_cnt_d  = err_inc ? sat_inc8(err_cnt_q) : err_cnt_q;

        if (clr_status) begin
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder with a behavioural uart_tx and byte-order scoreboard.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       full, empty;
    logic [4:0] level;
    logic       tx_enable, tx_write;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_error = 1'b0;
    logic       overflow, timeout;
    logic [7:0] err_cnt;
    logic       sw_clr = 1'b0;
    logic       mdl_clr = 1'b0;
    logic       clr_status;

    assign clr_status = sw_clr | mdl_clr;

    uart_tx_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .tx_enable (tx_enable),
        .tx_write  (tx_write),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .overflow  (overflow),
        .timeout   (timeout),
        .err_cnt   (err_cnt),
        .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    bit nobusy = 0;
    bit err_all = 0;
    bit rand_err = 0;
    bit clr_on_done = 0;
    bit cur_err = 0;
    int bcnt = 0;
    int exp_err = 0;
    int last_done = -1;
    int nwrites = 0;
    int gap_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural uart_tx: busy right after the write, done ten cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                tx_busy = 0; tx_done = 0; tx_error = 0; mdl_clr = 0; bcnt = 0;
            end else begin
                tx_done = 0; tx_error = 0; mdl_clr = 0;
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) begin
                        tx_busy = 0;
                        tx_done = 1;
                        tx_error = cur_err;
                        mdl_clr = clr_on_done;
                        last_done = cyc;
                        if (clr_on_done) exp_err = 0;
                        else if (cur_err && exp_err < 255) exp_err++;
                    end
                end
                if (tx_write) begin
                    got_q.push_back(tx_data);
                    nwrites++;
                    if (last_done >= 0) gap_q.push_back(cyc - last_done);
                    if (!nobusy) begin
                        tx_busy = 1;
                        bcnt = 10;
                        cur_err = err_all | (rand_err & ($urandom % 2 == 1));
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1; wr_data = b;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (n < 3000 && !(got_q.size() == exp_q.size() && empty && bcnt == 0 && !tx_busy)) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_sig(input string tag, input bit want_busy);
        int n = 0;
        while (n < 200 && !(want_busy ? tx_busy : tx_write)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(want_busy ? tx_busy : tx_write), 1);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        sw_clr = 1;
        @(negedge clk);
        sw_clr = 0;
        exp_err = 0;
    endtask

    initial begin
        logic [7:0] b;
        int w0;

        #12;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_write", 32'(tx_write), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_tmo", 32'(timeout), 0);
        chk("rst_err", 32'(err_cnt), 0);
        @(negedge clk);
        reset = 0;

        // Two bytes through a well-behaved transmitter.
        enable = 1;
        last_done = -1;
        gap_q.delete();
        push(8'hA5); exp_q.push_back(8'hA5);
        push(8'h3C); exp_q.push_back(8'h3C);
        drain("t1");
        chk("t1_gap", 32'(gap_q.size() > 0 ? gap_q[0] : -1), 2);
        chk("t1_nwr", 32'(nwrites), 2);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_en", 32'(tx_enable), 1);

        // Fill past capacity while the transmit path is held off.
        enable = 0;
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            if (i < 16) exp_q.push_back(8'(i));
            if (i == 15) begin
                chk("t2_full", 32'(full), 1);
                chk("t2_lvl16", 32'(level), 16);
                chk("t2_noovf", 32'(overflow), 0);
            end
        end
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_lvl", 32'(level), 16);
        @(negedge clk);
        enable = 1;
        drain("t2");
        clr_pulse();
        chk("t2_clr", 32'(overflow), 0);

        // Flush with a coincident push leaves nothing queued.
        enable = 0;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        chk("fl_lvl3", 32'(level), 3);
        @(negedge clk);
        flush = 1; wr_en = 1; wr_data = 8'h77;
        @(negedge clk);
        flush = 0; wr_en = 0;
        chk("fl_lvl0", 32'(level), 0);
        chk("fl_empty", 32'(empty), 1);
        w0 = nwrites;
        enable = 1;
        repeat (20) @(negedge clk);
        chk("fl_nowr", 32'(nwrites), 32'(w0));

        // Transmitter never goes busy.
        nobusy = 1;
        enable = 0;
        b = 8'($urandom); push(b); exp_q.push_back(b);
        b = 8'($urandom); push(b); exp_q.push_back(b);
        enable = 1;
        wait_sig("t3_wr", 0);
        repeat (4) @(negedge clk);
        chk("t3_tmo_early", 32'(timeout), 0);
        @(negedge clk);
        chk("t3_tmo", 32'(timeout), 1);
        chk("t3_err", 32'(err_cnt), 1);
        nobusy = 0;
        drain("t3");
        chk("t3_err2", 32'(err_cnt), 1);
        clr_pulse();
        chk("t3_clr_tmo", 32'(timeout), 0);
        chk("t3_clr_err", 32'(err_cnt), 0);

        // Error on completion, then clear racing a second error.
        err_all = 1;
        b = 8'($urandom); push(b); exp_q.push_back(b);
        drain("t4a");
        chk("t4_err1", 32'(err_cnt), 1);
        clr_on_done = 1;
        b = 8'($urandom); push(b); exp_q.push_back(b);
        drain("t4b");
        chk("t4_errclr", 32'(err_cnt), 0);
        clr_on_done = 0;
        err_all = 0;

        // Random bytes, random spacing, random transfer errors.
        rand_err = 1;
        exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
        end
        drain("t4r");
        chk("t4r_err", 32'(err_cnt), 32'(exp_err));
        rand_err = 0;

        // Disable during a transfer: byte abandoned, rest kept.
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom); push(b); exp_q.push_back(b);
        end
        enable = 1;
        wait_sig("t5_busy", 1);
        repeat (2) @(negedge clk);
        enable = 0;
        w0 = nwrites;
        repeat (15) @(negedge clk);
        chk("t5_nowr", 32'(nwrites), 32'(w0));
        chk("t5_lvl", 32'(level), 2);
        chk("t5_txen", 32'(tx_enable), 0);
        enable = 1;
        drain("t5");

        // Asynchronous reset in the middle of a transfer.
        enable = 0;
        for (int i = 0; i < 5; i++) push(8'($urandom) | 8'h01);
        enable = 1;
        wait_sig("t6_busy", 1);
        repeat (3) @(negedge clk);
        chk("t6_pre_lvl", 32'(level), 4);
        #1 reset = 1;
        #1;
        chk("t6_write", 32'(tx_write), 0);
        chk("t6_data", 32'(tx_data), 0);
        chk("t6_lvl", 32'(level), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_full", 32'(full), 0);
        chk("t6_err", 32'(err_cnt), 0);
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
